// File: rtl/cic_decim_comb_if.sv
// Sample bus for the CIC decimator/comb block: integrator samples in,
// decimated comb output out.
interface cic_decim_comb_if #(
  parameter int w = 10
);
  logic signed [w-1:0] din;
  logic                din_en;
  logic signed [w-1:0] dout;
  logic                dout_vld;

  modport master (output din, output din_en, input dout, input dout_vld);
  modport slave  (input din, input din_en, output dout, output dout_vld);
endinterface

// File: rtl/cic_decim_comb.sv
// CIC decimator + comb section. Keeps one integrator sample in every r
// accepted samples, then runs it through n pipelined first-difference
// stages. All arithmetic wraps modulo 2^w to match the upstream
// non-saturating integrators.

// One comb stage: x(k) = x(k-1) - d(k), d(k) = previous decimated input.
module cic_comb_stage #(
  parameter int w = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [w-1:0] x_i,
  input  logic         v_i,
  output logic [w-1:0] x_o,
  output logic         v_o
);
  logic [w-1:0] x_q, d_q, x_d;
  logic         v_q;

  // Modulo-2^w first difference; signedness is irrelevant for wrap math.
  always_comb x_d = x_i - d_q;

  // Advance only on a valid input; otherwise hold data, drop valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_q <= '0;
      d_q <= '0;
      v_q <= 1'b0;
    end else begin
      v_q <= v_i;
      if (v_i) begin
        x_q <= x_d;
        d_q <= x_i;
      end
    end
  end

  assign x_o = x_q;
  assign v_o = v_q;
endmodule

module cic_decim_comb #(
  parameter int w = 10,
  parameter int r = 8,
  parameter int n = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  cic_decim_comb_if.slave   bus
);
  localparam int            CW       = (r > 1) ? $clog2(r) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(r - 1);

  logic [CW-1:0]       cnt_q, cnt_d;
  logic                take;
  logic [w-1:0]        x0_q;
  logic                v0_q;
  logic [n:0][w-1:0]   x_pipe;
  logic [n:0]          vld_pipe;

  // Decimation counter: moves only on accepted samples, wraps at r-1.
  always_comb begin
    take  = bus.din_en && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (bus.din_en) cnt_d = take ? '0 : cnt_q + CW'(1);
  end

  // Capture every r-th accepted sample and raise a one-cycle valid.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      x0_q  <= '0;
      v0_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      v0_q  <= take;
      if (take) x0_q <= bus.din;
    end
  end

  assign x_pipe[0]   = x0_q;
  assign vld_pipe[0] = v0_q;

  // Comb chain; the valid flags alone drive the pipeline forward.
  for (genvar k = 1; k <= n; k++) begin : g_stage
    cic_comb_stage #(.w(w)) u_stage (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .x_i   (x_pipe[k-1]),
      .v_i   (vld_pipe[k-1]),
      .x_o   (x_pipe[k]),
      .v_o   (vld_pipe[k])
    );
  end

  assign bus.dout     = x_pipe[n];
  assign bus.dout_vld = vld_pipe[n];
endmodule

// File: tb/tb_cic_decim_comb.sv
// Directed bench: dut_a (r=4, n=2) covers reset, ramp, wrap, gapped enable
// and mid-flight reset; dut_b (r=1, n=3) covers continuous-rate impulse.
module tb_cic_decim_comb;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cic_decim_comb_if #(.w(W)) ia ();
  cic_decim_comb_if #(.w(W)) ib ();

  cic_decim_comb #(.w(W), .r(4), .n(2)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ia.slave));
  cic_decim_comb #(.w(W), .r(1), .n(3)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ib.slave));

  int total = 0;
  int passed = 0;
  int fails = 0;
  int ec = 0;          // rising-edge index
  int acc_a = 0;       // dut_a accepted samples since reset
  int qa_edge[$];      // edges after which a strobe is due
  int qb_edge[$];
  int va[$];           // hand-computed strobe values, in order
  int vb[$];
  int hold_a = 0;
  int hold_b = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, ec);
    end
  endtask

  // Drive one cycle, clock it, then check both DUTs 1ns after the edge.
  task automatic step(input logic r_, input logic ena, input int da,
                      input logic enb, input int db);
    logic ea, eb;
    rst = r_;
    ia.din = W'(da); ia.din_en = ena;
    ib.din = W'(db); ib.din_en = enb;
    @(posedge clk);
    ec++;
    if (r_) begin
      acc_a = 0;
      qa_edge.delete(); qb_edge.delete();
      hold_a = 0; hold_b = 0;
    end else begin
      if (ena) begin
        acc_a++;
        if (acc_a % 4 == 0) qa_edge.push_back(ec + 2);
      end
      if (enb) qb_edge.push_back(ec + 3);
    end
    #1;
    ea = (qa_edge.size() > 0) && (qa_edge[0] == ec);
    eb = (qb_edge.size() > 0) && (qb_edge[0] == ec);
    chk("a_vld", int'(ia.dout_vld), int'(ea));
    chk("b_vld", int'(ib.dout_vld), int'(eb));
    if (ea) begin
      void'(qa_edge.pop_front());
      if (va.size() > 0) hold_a = va.pop_front();
    end
    if (eb) begin
      void'(qb_edge.pop_front());
      if (vb.size() > 0) hold_b = vb.pop_front();
    end
    chk("a_dout", int'(ia.dout), hold_a);
    chk("b_dout", int'(ib.dout), hold_b);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    int pat[7];
    int k;
    pat = '{1, 0, 1, 1, 0, 0, 1};

    // Reset with random inputs, then idle: outputs stay zero.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'(($urandom & 1)), int'($urandom_range(0, 1023)),
                 1'(($urandom & 1)), int'($urandom_range(0, 1023)));
    idle(3);

    // Ramp 1..16: strobes 2 edges after every 4th sample, values 4,0,0,0.
    va = '{4, 0, 0, 0};
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, i, 1'b0, 0);
    idle(3);
    step(1'b1, 1'b0, 0, 1'b0, 0);

    // Wrap-around: decimated 400,800,176,576 -> differences 400 -> 400,0,0,0.
    va = '{400, 0, 0, 0};
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, (100 * i) % 1024, 1'b0, 0);
    idle(3);
    step(1'b1, 1'b0, 0, 1'b0, 0);

    // Gapped enable 1,0,1,1,0,0,1 with ramp on accepted samples.
    va = '{4, 0, 0, 0};
    k = 0;
    for (int i = 0; k < 16; i++) begin
      if (pat[i % 7] == 1) begin
        k++;
        step(1'b0, 1'b1, k, 1'b0, 0);
      end else begin
        step(1'b0, 1'b0, 999, 1'b0, 0);
      end
    end
    idle(3);
    step(1'b1, 1'b0, 0, 1'b0, 0);

    // Reset one cycle after a capture: in-flight sample must vanish.
    va = '{4, 0, 0};
    for (int i = 1; i <= 16; i++) step(1'b0, 1'b1, i, 1'b0, 0);
    step(1'b1, 1'b1, 17, 1'b0, 0);
    idle(3);
    va = '{4, 0, 0};
    for (int i = 1; i <= 12; i++) step(1'b0, 1'b1, i, 1'b0, 0);
    idle(3);
    step(1'b1, 1'b0, 0, 1'b0, 0);

    // r=1, n=3 impulse: third difference 5,-15,15,-5,0,...
    vb = '{5, -15, 15, -5, 0, 0, 0, 0};
    step(1'b0, 1'b0, 0, 1'b1, 5);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 1'b1, 0);
    idle(4);

    chk("a_drain", qa_edge.size() + va.size(), 0);
    chk("b_drain", qb_edge.size() + vb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
